// File: rtl/fetch_decode_pkg.sv
// Shared definitions for the fetch/decode front end: widths, opcodes,
// instruction field positions and the decoded-field bundle.
package fetch_decode_pkg;

   localparam int PC_W    = 6;
   localparam int INSTR_W = 16;
   localparam logic [PC_W-1:0] RESET_PC = '0;

   // instruction field bit positions
   localparam int OPC_MSB   = 15;
   localparam int OPC_LSB   = 11;
   localparam int AM_BIT    = 10;
   localparam int RD_MSB    = 9;
   localparam int RD_LSB    = 7;
   localparam int RS_MSB    = 6;
   localparam int RS_LSB    = 4;
   localparam int MADDR_MSB = 3;
   localparam int MADDR_LSB = 0;
   localparam int TGT_MSB   = PC_W - 1;
   localparam int TGT_LSB   = 0;

   localparam logic [4:0] OP_NOP   = 5'b00000;
   localparam logic [4:0] OP_ADD   = 5'b00001;
   localparam logic [4:0] OP_MUL   = 5'b00011;
   localparam logic [4:0] OP_INC   = 5'b00101;
   localparam logic [4:0] OP_STORE = 5'b01100;
   localparam logic [4:0] OP_JUMP  = 5'b01101;
   localparam logic [4:0] OP_BEQZ  = 5'b01110;
   localparam logic [4:0] OP_BPAR  = 5'b11000;
   localparam logic [4:0] OP_HALT  = 5'b11111;

   typedef struct packed {
      logic [4:0]      opcode;
      logic            am;
      logic [2:0]      rd;
      logic [2:0]      rs;
      logic [3:0]      mem_addr;
      logic [PC_W-1:0] instr_mem_addr;
      logic            is_branch;
      logic            is_halt;
   } dec_fields_t;

   // Branch-class opcodes stall the front end until write_back resolves them.
   function automatic logic is_branch_op(input logic [4:0] op);
      return (op == OP_JUMP) || (op == OP_BEQZ) || (op == OP_BPAR);
   endfunction

endpackage

// File: rtl/fetch_decode_if.sv
// Bus bundle between the front end, instruction memory, write_back and
// the branch-resolution feedback path.
interface fetch_decode_if;
   import fetch_decode_pkg::*;

   logic               imem_en;
   logic [PC_W-1:0]    imem_addr;
   logic [INSTR_W-1:0] imem_rdata;

   logic               dec_valid;
   logic               dec_ready;
   logic [4:0]         opcode;
   logic               am;
   logic [2:0]         rd;
   logic [2:0]         rs;
   logic [3:0]         mem_addr;
   logic [PC_W-1:0]    instr_mem_addr;
   logic [PC_W-1:0]    pc_out;

   logic               wb_br_done;
   logic               wb_br_taken;
   logic [PC_W-1:0]    wb_br_target;

   logic               halted;

   modport master (
      output imem_en, imem_addr,
      input  imem_rdata,
      output dec_valid,
      input  dec_ready,
      output opcode, am, rd, rs, mem_addr, instr_mem_addr, pc_out,
      input  wb_br_done, wb_br_taken, wb_br_target,
      output halted
   );

   modport slave (
      input  imem_en, imem_addr,
      output imem_rdata,
      input  dec_valid,
      output dec_ready,
      input  opcode, am, rd, rs, mem_addr, instr_mem_addr, pc_out,
      output wb_br_done, wb_br_taken, wb_br_target,
      input  halted
   );

endinterface

// File: rtl/fetch_decode_instr_field_decode.sv
// Combinational split of an instruction word into its fields plus a
// branch/halt classification used by the issue stage.
module fetch_decode_instr_field_decode
   import fetch_decode_pkg::*;
(
   input  logic [INSTR_W-1:0] instr,
   output dec_fields_t        fields
);

   // Field extraction; unknown opcodes pass through and classify as sequential.
   always_comb begin
      fields                = '0;
      fields.opcode         = instr[OPC_MSB:OPC_LSB];
      fields.am             = instr[AM_BIT];
      fields.rd             = instr[RD_MSB:RD_LSB];
      fields.rs             = instr[RS_MSB:RS_LSB];
      fields.mem_addr       = instr[MADDR_MSB:MADDR_LSB];
      fields.instr_mem_addr = instr[TGT_MSB:TGT_LSB];
      fields.is_branch      = is_branch_op(instr[OPC_MSB:OPC_LSB]);
      fields.is_halt        = (instr[OPC_MSB:OPC_LSB] == OP_HALT);
   end

endmodule

// File: rtl/fetch_decode.sv
// Front end of the 8-bit core: fetches 16-bit instructions from a
// sync-read instruction memory, decodes them and offers the fields to
// write_back with a valid/ready handshake. Branches stall the front end
// until write_back reports the outcome.
//
//   state   | meaning
//   --------+---------------------------------------------------------
//   FETCH   | imem read strobe for pc
//   DECODE  | imem data arrives; capture fields and pc into output regs
//   ISSUE   | dec_valid high, fields held until dec_ready
//   BR_WAIT | branch issued; wait for wb_br_done to pick the next pc
//   HALT    | HALT issued; front end stopped until reset
module fetch_decode
   import fetch_decode_pkg::*;
(
   input  logic          clk,
   input  logic          rst_n,
   fetch_decode_if.master bus
);

   typedef enum logic [2:0] {
      S_FETCH   = 3'd0,
      S_DECODE  = 3'd1,
      S_ISSUE   = 3'd2,
      S_BR_WAIT = 3'd3,
      S_HALT    = 3'd4
   } state_t;

   state_t          state_q, state_d;
   logic [PC_W-1:0] pc_q, pc_d;
   logic [PC_W-1:0] pc_out_q, pc_out_d;
   dec_fields_t     fields_q, fields_d;
   dec_fields_t     rdata_fields;

   fetch_decode_instr_field_decode u_field_decode (
      .instr  (bus.imem_rdata),
      .fields (rdata_fields)
   );

   // State, pc and output-field registers; reset drops any in-flight read.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_FETCH;
         pc_q     <= RESET_PC;
         pc_out_q <= '0;
         fields_q <= '0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         pc_out_q <= pc_out_d;
         fields_q <= fields_d;
      end
   end

   // Next-state, pc update and field capture.
   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      pc_out_d = pc_out_q;
      fields_d = fields_q;
      case (state_q)
         S_FETCH: begin
            state_d = S_DECODE;
         end
         S_DECODE: begin
            fields_d = rdata_fields;
            pc_out_d = pc_q;
            state_d  = S_ISSUE;
         end
         S_ISSUE: begin
            if (bus.dec_ready) begin
               if (fields_q.is_halt) begin
                  state_d = S_HALT;
               end else if (fields_q.is_branch) begin
                  state_d = S_BR_WAIT;
               end else begin
                  pc_d    = pc_q + PC_W'(1);
                  state_d = S_FETCH;
               end
            end
         end
         S_BR_WAIT: begin
            if (bus.wb_br_done) begin
               pc_d    = bus.wb_br_taken ? bus.wb_br_target : pc_q + PC_W'(1);
               state_d = S_FETCH;
            end
         end
         S_HALT: begin
            state_d = S_HALT;
         end
         default: begin
            state_d = S_FETCH;
         end
      endcase
   end

   // The reset state is FETCH, so the strobe is masked while reset is held
   // to keep every output low during reset.
   assign bus.imem_en        = rst_n & (state_q == S_FETCH);
   assign bus.imem_addr      = pc_q;
   assign bus.dec_valid      = (state_q == S_ISSUE);
   assign bus.halted         = (state_q == S_HALT);
   assign bus.opcode         = fields_q.opcode;
   assign bus.am             = fields_q.am;
   assign bus.rd             = fields_q.rd;
   assign bus.rs             = fields_q.rs;
   assign bus.mem_addr       = fields_q.mem_addr;
   assign bus.instr_mem_addr = fields_q.instr_mem_addr;
   assign bus.pc_out         = pc_out_q;

endmodule

// File: tb/tb_fetch_decode.sv
// Directed + randomized bench for fetch_decode against a 64x16 sync-read
// ROM and a program-counter reference model.
module tb_fetch_decode;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   fetch_decode_if bus ();

   fetch_decode dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   logic [15:0] rom [64];
   logic [15:0] rdata_r;
   always @(posedge clk) if (bus.imem_en) rdata_r <= rom[bus.imem_addr];
   assign bus.imem_rdata = rdata_r;

   int n_cmp = 0;
   int n_mis = 0;
   int m_pc  = 0;

   localparam logic [4:0] JUMP = 5'b01101, BEQZ = 5'b01110, BPAR = 5'b11000, HALT = 5'b11111;

   initial begin
      #400000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input string what, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_mis++;
         $error("FAIL %s.%s: observed %0h expected %0h", tag, what, obs, exp);
      end
   endtask

   function automatic bit is_br(input logic [15:0] ins);
      logic [4:0] op;
      op = ins[15:11];
      return op == JUMP || op == BEQZ || op == BPAR;
   endfunction

   function automatic logic [15:0] rand_instr(input bit allow_br);
      logic [4:0] op;
      if (allow_br && $urandom_range(0, 3) == 0) begin
         case ($urandom_range(0, 2))
            0: op = JUMP;
            1: op = BEQZ;
            default: op = BPAR;
         endcase
      end else begin
         op = 5'($urandom_range(0, 31));
         while (op == JUMP || op == BEQZ || op == BPAR || op == HALT) op = 5'($urandom_range(0, 31));
      end
      return {op, 11'($urandom)};
   endfunction

   task automatic check_all_clear(input string tag);
      check(tag, "imem_en", bus.imem_en, 0);
      check(tag, "imem_addr", bus.imem_addr, 0);
      check(tag, "dec_valid", bus.dec_valid, 0);
      check(tag, "opcode", bus.opcode, 0);
      check(tag, "am", bus.am, 0);
      check(tag, "rd", bus.rd, 0);
      check(tag, "rs", bus.rs, 0);
      check(tag, "mem_addr", bus.mem_addr, 0);
      check(tag, "instr_mem_addr", bus.instr_mem_addr, 0);
      check(tag, "pc_out", bus.pc_out, 0);
      check(tag, "halted", bus.halted, 0);
   endtask

   task automatic check_fields(input string tag, input int pc);
      logic [15:0] ins;
      ins = rom[pc];
      check(tag, "opcode", bus.opcode, ins[15:11]);
      check(tag, "am", bus.am, ins[10]);
      check(tag, "rd", bus.rd, ins[9:7]);
      check(tag, "rs", bus.rs, ins[6:4]);
      check(tag, "mem_addr", bus.mem_addr, ins[3:0]);
      check(tag, "instr_mem_addr", bus.instr_mem_addr, ins[5:0]);
      check(tag, "pc_out", bus.pc_out, pc);
   endtask

   // Called at the negedge where the front end should be fetching m_pc.
   task automatic expect_issue(input string tag);
      int waited;
      waited = 0;
      check(tag, "fetch_en", bus.imem_en, 1);
      check(tag, "fetch_addr", bus.imem_addr, m_pc);
      while (!bus.dec_valid && waited < 10) begin
         @(negedge clk);
         waited++;
      end
      check(tag, "latency", waited, 2);
      check(tag, "halted", bus.halted, 0);
      check_fields(tag, m_pc);
   endtask

   // Holds dec_ready low for hold cycles, then performs one handshake.
   task automatic issue_and_accept(input string tag, input int hold);
      expect_issue(tag);
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         check(tag, "hold_valid", bus.dec_valid, 1);
         check(tag, "hold_en", bus.imem_en, 0);
         check_fields(tag, m_pc);
      end
      bus.dec_ready = 1'b1;
      @(negedge clk);
      bus.dec_ready = 1'b0;
   endtask

   task automatic advance_seq();
      m_pc = (m_pc + 1) % 64;
   endtask

   task automatic do_branch(input string tag, input int idle, input bit taken, input int target);
      for (int i = 0; i < idle; i++) begin
         check(tag, "wait_valid", bus.dec_valid, 0);
         check(tag, "wait_en", bus.imem_en, 0);
         bus.wb_br_taken  = 1'b1;
         bus.wb_br_target = 6'($urandom);
         @(negedge clk);
      end
      check(tag, "wait_valid", bus.dec_valid, 0);
      bus.wb_br_done   = 1'b1;
      bus.wb_br_taken  = taken;
      bus.wb_br_target = 6'(target);
      @(negedge clk);
      bus.wb_br_done   = 1'b0;
      bus.wb_br_taken  = 1'b0;
      bus.wb_br_target = '0;
      m_pc = taken ? target : (m_pc + 1) % 64;
   endtask

   initial begin
      logic [15:0] ins;
      bus.dec_ready    = 1'b0;
      bus.wb_br_done   = 1'b0;
      bus.wb_br_taken  = 1'b0;
      bus.wb_br_target = '0;
      for (int i = 0; i < 64; i++) rom[i] = rand_instr(1'b1);
      rom[0]  = {5'b00001, 1'b0, 3'd1, 3'd2, 4'd3};
      rom[1]  = rand_instr(1'b0);
      rom[2]  = {JUMP, 1'b0, 3'd0, 7'd5};
      rom[4]  = {BPAR, 11'($urandom)};
      rom[5]  = {BEQZ, 11'($urandom)};
      rom[6]  = {BEQZ, 11'($urandom)};
      rom[62] = rand_instr(1'b0);
      rom[63] = rand_instr(1'b0);

      // reset state
      repeat (3) @(negedge clk);
      check_all_clear("reset");

      // first instruction with dec_ready already high while dec_valid is low
      bus.dec_ready = 1'b1;
      rst_n = 1'b1;
      #1;
      m_pc = 0;
      expect_issue("t1");
      check("t1", "add_opcode", bus.opcode, 5'b00001);
      check("t1", "add_rd", bus.rd, 3'b001);
      @(negedge clk);
      bus.dec_ready = 1'b0;
      advance_seq();

      // back-pressure on ROM[1]
      issue_and_accept("t2", 5);
      advance_seq();

      // JUMP with a 4-cycle resolution wait and stray taken without done
      issue_and_accept("t3", 0);
      do_branch("t3", 4, 1'b1, 5);

      // BEQZ not taken, then BEQZ taken to 4, BPAR redirect to 62
      issue_and_accept("t4a", 0);
      do_branch("t4a", 1, 1'b0, 0);
      issue_and_accept("t4b", 0);
      do_branch("t4b", 0, 1'b1, 4);
      issue_and_accept("t4c", 1);
      do_branch("t4c", 2, 1'b1, 62);

      // stray wb_br_done during ISSUE, then pc wrap 63 -> 0
      expect_issue("t5a");
      bus.wb_br_done   = 1'b1;
      bus.wb_br_taken  = 1'b1;
      bus.wb_br_target = 6'd20;
      @(negedge clk);
      bus.wb_br_done   = 1'b0;
      bus.wb_br_taken  = 1'b0;
      check("t5a", "stray_valid", bus.dec_valid, 1);
      check_fields("t5a", m_pc);
      bus.dec_ready = 1'b1;
      @(negedge clk);
      bus.dec_ready = 1'b0;
      advance_seq();
      issue_and_accept("t5b", 0);
      advance_seq();
      check("t5c", "wrap_addr", bus.imem_addr, 0);
      issue_and_accept("t5c", 0);
      advance_seq();
      issue_and_accept("t5d", 0);
      advance_seq();
      issue_and_accept("t5e", 0);
      do_branch("t5e", 0, 1'b1, 7);

      // randomized program walk
      for (int n = 0; n < 60; n++) begin
         ins = rom[m_pc];
         issue_and_accept("rnd", $urandom_range(0, 3));
         if (is_br(ins)) do_branch("rnd", $urandom_range(0, 3), 1'($urandom_range(0, 1)), $urandom_range(0, 63));
         else advance_seq();
      end

      // reset mid-operation, then mid-DECODE, then HALT from RESET_PC
      rom[0] = {HALT, 11'($urandom)};
      rst_n = 1'b0;
      #1;
      check_all_clear("rst_mid");
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("rst_dec", "pre_valid", bus.dec_valid, 0);
      rst_n = 1'b0;
      #1;
      check_all_clear("rst_dec");
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      m_pc = 0;
      issue_and_accept("t6", 0);
      for (int i = 0; i < 5; i++) begin
         check("t6", "halted", bus.halted, 1);
         check("t6", "valid", bus.dec_valid, 0);
         check("t6", "imem_en", bus.imem_en, 0);
         bus.wb_br_done  = (i == 2);
         bus.wb_br_taken = (i == 2);
         bus.dec_ready   = 1'b1;
         @(negedge clk);
      end
      bus.wb_br_done  = 1'b0;
      bus.wb_br_taken = 1'b0;
      bus.dec_ready   = 1'b0;
      check("t6", "halted_end", bus.halted, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
